csr_unit: RTL

//  Machine-mode CSR file with full CSRRW/CSRRS/CSRRC read-modify-write, trap entry/MRET state update,

---
 rtl/csr_unit.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit -- machine-mode CSR file
//
// Combinational read of the addressed CSR, read-modify-write update at the
// clock edge, trap entry / MRET bookkeeping, interrupt-pending generation
// and 64-bit mcycle / minstret counters.
//
// Parameters
//   XLEN         data width, 32 or 64
//   HART_ID      value returned by mhartid
//   MTVEC_RESET  reset value of mtvec
//
// Build option
//   CSR_COUNTERS_EN  when defined, mcycle/minstret (and the high halves at
//                    XLEN=32) are real counters; when undefined the counter
//                    addresses are legal, read 0 and ignore writes.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   csr_we_i        CSR write strobe
//   csr_op_i        01 RW, 10 RS, 11 RC, 00 no write
//   csr_addr_i      CSR address for read and write
//   csr_wdata_i     rs1/zimm operand
//   csr_rdata_o     old value of the addressed CSR (combinational)
//   illegal_o       unimplemented CSR, or write attempt to a read-only CSR
//   trap_i          take trap this cycle (cause/pc/val qualify it)
//   trap_cause_i, trap_pc_i, trap_val_i
//   mret_i          MRET retiring this cycle
//   instret_i       one instruction retired this cycle
//   irq_ext_i, irq_timer_i   interrupt levels, registered into mip
//   irq_pending_o   enabled interrupt pending (from registers only)
//   trap_vec_o      trap target PC
//   mepc_o          current mepc (MRET target)
//
// Same-cycle priority: reset > trap > MRET > software write. Fields a
// higher-priority event updates ignore the lower-priority update.
// ---------------------------------------------------------------------------
module csr_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_we_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            illegal_o,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_val_i,
   input  logic            mret_i,
   input  logic            instret_i,
   input  logic            irq_ext_i,
   input  logic            irq_timer_i,
   output logic            irq_pending_o,
   output logic [XLEN-1:0] trap_vec_o,
   output logic [XLEN-1:0] mepc_o
);

   logic            mie_q, mie_d;       // mstatus.MIE
   logic            mpie_q, mpie_d;     // mstatus.MPIE
   logic            meie_q, meie_d;
   logic            mtie_q, mtie_d;
   logic            meip_q, meip_d;
   logic            mtip_q, mtip_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
   logic [63:0]     mcycle_q, mcycle_d;
   logic [63:0]     minstret_q, minstret_d;
`else
   logic            unused_instret;
   assign unused_instret = instret_i;
`endif

   logic [XLEN-1:0] rdata;
   logic [XLEN-1:0] wval;
   logic [XLEN-1:0] vec_off;
   logic            legal;
   logic            read_only;
   logic            wr_en;

   // Read mux: also classifies the address as legal / read-only.
   always_comb begin
      rdata     = '0;
      legal     = 1'b1;
      read_only = 1'b0;
      case (csr_addr_i)
         12'h300: begin
            rdata[3]     = mie_q;
            rdata[7]     = mpie_q;
            rdata[12:11] = 2'b11;             // MPP hardwired to M-mode
         end
         12'h301: begin
            rdata[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
            rdata[8]             = 1'b1;      // I extension
            read_only            = 1'b1;
         end
         12'h304: begin
            rdata[11] = meie_q;
            rdata[7]  = mtie_q;
         end
         12'h305: rdata = mtvec_q;
         12'h340: rdata = mscratch_q;
         12'h341: rdata = mepc_q;
         12'h342: rdata = mcause_q;
         12'h343: rdata = mtval_q;
         12'h344: begin
            rdata[11] = meip_q;
            rdata[7]  = mtip_q;
         end
`ifdef CSR_COUNTERS_EN
         12'hB00: rdata = mcycle_q[XLEN-1:0];
         12'hB02: rdata = minstret_q[XLEN-1:0];
         12'hB80: if (XLEN == 32) rdata[31:0] = mcycle_q[63:32];   else legal = 1'b0;
         12'hB82: if (XLEN == 32) rdata[31:0] = minstret_q[63:32]; else legal = 1'b0;
`else
         12'hB00, 12'hB02: rdata = '0;
         12'hB80, 12'hB82: legal = (XLEN == 32);
`endif
         12'hF14: begin
            rdata     = HART_ID;
            read_only = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op_i)
         2'b01:   wval = csr_wdata_i;
         2'b10:   wval = rdata | csr_wdata_i;
         2'b11:   wval = rdata & ~csr_wdata_i;
         default: wval = rdata;
      endcase
   end

   assign wr_en       = csr_we_i && (csr_op_i != 2'b00) && legal && !read_only;
   assign illegal_o   = !legal || (csr_we_i && (csr_op_i != 2'b00) && read_only);
   assign csr_rdata_o = rdata;

   // Next-state: software write first, then MRET, then trap, so later
   // assignments implement the priority order.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtie_d     = mtie_q;
      meip_d     = irq_ext_i;
      mtip_d     = irq_timer_i;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
`ifdef CSR_COUNTERS_EN
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, instret_i};
`endif
      if (wr_en) begin
         case (csr_addr_i)
            12'h300: begin
               mie_d  = wval[3];
               mpie_d = wval[7];
            end
            12'h304: begin
               meie_d = wval[11];
               mtie_d = wval[7];
            end
            // Reserved modes 1x fall back to direct mode.
            12'h305: mtvec_d = wval[1] ? {wval[XLEN-1:2], 2'b00} : wval;
            12'h340: mscratch_d = wval;
            12'h341: mepc_d     = {wval[XLEN-1:2], 2'b00};
            12'h342: mcause_d   = wval;
            12'h343: mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
            12'hB00: begin
               mcycle_d              = mcycle_q;
               mcycle_d[XLEN-1:0]    = wval;
            end
            12'hB02: begin
               minstret_d            = minstret_q;
               minstret_d[XLEN-1:0]  = wval;
            end
            12'hB80: begin
               mcycle_d              = mcycle_q;
               mcycle_d[63:32]       = wval[31:0];
            end
            12'hB82: begin
               minstret_d            = minstret_q;
               minstret_d[63:32]     = wval[31:0];
            end
`endif
            default: ;
         endcase
      end
      if (mret_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
      if (trap_i) begin
         mepc_d   = {trap_pc_i[XLEN-1:2], 2'b00};
         mcause_d = trap_cause_i;
         mtval_d  = trap_val_i;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         meip_q     <= 1'b0;
         mtip_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= '0;
         minstret_q <= '0;
`endif
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         meie_q     <= meie_d;
         mtie_q     <= mtie_d;
         meip_q     <= meip_d;
         mtip_q     <= mtip_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
`endif
      end
   end

   assign irq_pending_o = mie_q && ((meie_q && meip_q) || (mtie_q && mtip_q));
   assign mepc_o        = mepc_q;

   // Vectored offset is 4*cause[5:0]; only interrupts are vectored.
   always_comb begin
      vec_off      = '0;
      vec_off[7:2] = trap_cause_i[5:0];
      if (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
         trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00} + vec_off;
      else
         trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00};
   end

endmodule
